mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, word-addressed memory between the instruction-fetch requester (port i) and the data-memory requester (port d).
- Sits between the fetch/memory stages and the memory macro. Serialises accesses with a registered req/ack handshake and gives priority to data, with a starvation guard for fetch.
- Drives a stall signal that holds the pipeline while either requester is waiting.

Parameters:
ADDR_W, 32, address width (word address; PC steps by 1)
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while fetch waits (>=1)
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid when d_ack=1 and access was a read
d_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only in ACCESS
mem_err  out  1  sticky timeout flag
pipe_stall  out  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack)

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - The following outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, mem_err, the streak counter, the timeout counter and the owner register.
  - Any in-flight access is abandoned and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Data wins if d_req=1 and not (if_req=1 and streak==STARVE_LIMIT). Otherwise fetch wins if if_req=1. With no request, stay in IDLE.
  - On a grant, register owner, mem_addr, mem_we (= d_we for data, 0 for fetch) and mem_wdata (= d_wdata for data, unchanged for fetch). Set mem_en=1, clear the timeout counter and go to ACCESS.
- Streak counter:
  - Data grant while if_req=1: streak+1, saturating at STARVE_LIMIT.
  - Data grant while if_req=0: streak=0.
  - Fetch grant: streak=0.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable. The timeout counter increments each cycle.
  - mem_ready=1: capture mem_rdata into the owner's rdata register, except on a data write, where d_rdata is unchanged. Set the owner's ack=1, mem_en=0, mem_we=0 and go to RESP.
  - Timeout counter reaches TIMEOUT-1 with mem_ready=0: owner's rdata=0 (a data write leaves d_rdata unchanged), owner's ack=1, mem_err=1, mem_en=0, mem_we=0, go to RESP.
  - mem_ready in the same cycle as the timeout: treat as a normal completion; mem_err is not set.
- RESP:
  - Ack is high for exactly this one cycle. Clear ack and go to IDLE; no arbitration in RESP.
  - Requesters drop or change their request at the edge ending RESP. The next IDLE cycle samples fresh requests.
- Latency and throughput:
  - Request visible at edge N → mem_en=1 from edge N+1.
  - With mem_ready=1 in the first ACCESS cycle → ack visible from edge N+2 to N+3.
  - Minimum 3 cycles per access. Back-to-back accesses issue every 3 cycles.
- Requester dropping req during ACCESS is a protocol violation. The access still completes and ack still pulses.
- mem_err stays set until reset. It does not block further accesses.
- Only one ack is ever high in a cycle. mem_en is never high outside ACCESS.

Test Plan:
1. Fetch only: if_addr=5, mem_ready=1 in the first ACCESS cycle, mem_rdata=0x8C220004 → mem_en=1 for 1 cycle with mem_addr=5, mem_we=0; if_ack pulses 1 cycle later with if_rdata=0x8C220004; pipe_stall=1 until the ack cycle.
2. Simultaneous if_req and d_req: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → first access mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, then d_ack with d_rdata unchanged; fetch is granted next in IDLE.
3. Starvation guard: d_req and if_req held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each F.
4. Timeout: d_req read at addr 0x20, mem_ready never asserted, TIMEOUT=8 → d_ack after 8 ACCESS cycles with d_rdata=0 and mem_err=1 (sticky); a following fetch with mem_ready completes normally and mem_err stays 1.
5. Reset mid-ACCESS: reset_n=0 while mem_en=1 → mem_en, acks and mem_err are 0 immediately (before the next edge). After release with if_req held, there is a fresh grant, mem_en rises 1 cycle later and exactly one if_ack is seen.
6. Boundary: mem_ready=1 in the same cycle the timeout count expires → normal completion with rdata=mem_rdata and mem_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-macro signals seen by
// mem_port_arbiter. The arbiter takes the slave view; the pipeline/memory
// side (or a bench) takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // data-memory port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // memory macro side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // status
  logic              mem_err;
  logic              pipe_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           mem_err, pipe_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           mem_err, pipe_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported memory. Data accesses
// win by default; a streak counter lets fetch through after STARVE_LIMIT
// consecutive data grants taken while fetch was waiting. Each access is
// IDLE -> ACCESS -> RESP, with a timeout that completes the access with
// zero read data and raises a sticky error flag.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q,     state_nx;
  logic              owner_d_q,   owner_d_nx;   // 1: data port owns the access
  logic [SW-1:0]     streak_q,    streak_nx;
  logic [TW-1:0]     tcnt_q,      tcnt_nx;
  logic              mem_en_q,    mem_en_nx;
  logic              mem_we_q,    mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nx;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_nx;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_nx;
  logic              if_ack_q,    if_ack_nx;
  logic              d_ack_q,     d_ack_nx;
  logic              mem_err_q,   mem_err_nx;
  logic              d_wins;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_nx     = state_q;
    owner_d_nx   = owner_d_q;
    streak_nx    = streak_q;
    tcnt_nx      = tcnt_q;
    mem_en_nx    = mem_en_q;
    mem_we_nx    = mem_we_q;
    mem_addr_nx  = mem_addr_q;
    mem_wdata_nx = mem_wdata_q;
    if_rdata_nx  = if_rdata_q;
    d_rdata_nx   = d_rdata_q;
    if_ack_nx    = 1'b0;
    d_ack_nx     = 1'b0;
    mem_err_nx   = mem_err_q;
    d_wins       = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (d_wins) begin
          owner_d_nx   = 1'b1;
          mem_addr_nx  = bus.d_addr;
          mem_we_nx    = bus.d_we;
          mem_wdata_nx = bus.d_wdata;
          if (!bus.if_req)                streak_nx = '0;
          else if (streak_q != STREAK_MAX) streak_nx = streak_q + 1'b1;
          mem_en_nx    = 1'b1;
          tcnt_nx      = '0;
          state_nx     = ACCESS;
        end else if (bus.if_req) begin
          // fetch keeps the last write data on the bus untouched
          owner_d_nx   = 1'b0;
          mem_addr_nx  = bus.if_addr;
          mem_we_nx    = 1'b0;
          streak_nx    = '0;
          mem_en_nx    = 1'b1;
          tcnt_nx      = '0;
          state_nx     = ACCESS;
        end
      end
      ACCESS: begin
        tcnt_nx = tcnt_q + 1'b1;
        // a ready on the last allowed cycle still counts as a clean completion
        if (bus.mem_ready || (tcnt_q == TCNT_LAST)) begin
          if (owner_d_q) begin
            d_ack_nx = 1'b1;
            if (!mem_we_q) d_rdata_nx = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            if_ack_nx   = 1'b1;
            if_rdata_nx = bus.mem_ready ? bus.mem_rdata : '0;
          end
          if (!bus.mem_ready) mem_err_nx = 1'b1;
          mem_en_nx = 1'b0;
          mem_we_nx = 1'b0;
          state_nx  = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nx;
      owner_d_q   <= owner_d_nx;
      streak_q    <= streak_nx;
      tcnt_q      <= tcnt_nx;
      mem_en_q    <= mem_en_nx;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      if_rdata_q  <= if_rdata_nx;
      d_rdata_q   <= d_rdata_nx;
      if_ack_q    <= if_ack_nx;
      d_ack_q     <= d_ack_nx;
      mem_err_q   <= mem_err_nx;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.pipe_stall = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule
